// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the CORDIC post-processing path.
// K is realised as five signed power-of-two terms: 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13.
package cordic_pkg;

    localparam int INT_W     = 7;
    localparam int FRAC_W    = 8;
    localparam int DATA_W    = 1 + INT_W + FRAC_W;
    localparam int GUARD_W   = 13;
    localparam int NUM_TERMS = 5;
    localparam int NUM_CH    = 2;
    localparam int MAG_W     = DATA_W + 1;
    localparam int ACC_W     = MAG_W + GUARD_W;
    localparam int IDX_W     = 3;

    localparam logic [NUM_TERMS-1:0][3:0] K_SHIFT = {4'd13, 4'd9, 4'd6, 4'd3, 4'd1};
    localparam logic [NUM_TERMS-1:0]      K_NEG   = 5'b11100;

    localparam logic [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (GUARD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ROUND,
        DONE
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [DATA_W-2:0] mag;
    } q78_sm_t;

    // |v| needs one extra bit so that -32768 keeps its true magnitude.
    function automatic logic [MAG_W-1:0] abs_mag(input logic [DATA_W-1:0] v);
        logic [MAG_W-1:0] ext;
        ext = {v[DATA_W-1], v};
        return v[DATA_W-1] ? ((~ext) + MAG_W'(1)) : ext;
    endfunction

    function automatic logic [ACC_W-1:0] k_term(input logic [MAG_W-1:0] mag,
                                                input logic [IDX_W-1:0] idx);
        logic [ACC_W-1:0] scaled;
        scaled = ACC_W'(mag) << GUARD_W;
        return scaled >> K_SHIFT[idx];
    endfunction

endpackage

// File: rtl/cordic_gain_comp_if.sv
// Upstream/downstream handshake bundle for the gain compensation stage.
interface cordic_gain_comp_if;
    import cordic_pkg::*;

    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] res1_in;
    logic [DATA_W-1:0] res2_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic              out_ovf;

    modport master (
        output mode, in_valid, res1_in, res2_in, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_ovf
    );

    modport slave (
        input  mode, in_valid, res1_in, res2_in, out_ready,
        output in_ready, out_valid, out_x, out_y, out_ovf
    );

endinterface

// File: rtl/cordic_sm_pack.sv
// Sign plus 17-bit magnitude to sign-magnitude Q7.8, saturating to 0xFFFF.
module cordic_sm_pack
    import cordic_pkg::*;
(
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    output q78_sm_t          sm,
    output logic             sat
);

    always_comb begin
        sat = |mag[MAG_W-1:DATA_W-1];
        sm  = '0;
        if (sat) begin
            sm = '1;
        end else begin
            // Zero magnitude never carries a sign bit.
            sm.sign = sign & (|mag);
            sm.mag  = mag[DATA_W-2:0];
        end
    end

endmodule

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain from a res1/res2 pair with a sequential shift-add by K,
// rounds half-up on the magnitude and returns sign-magnitude Q7.8 results.
module cordic_gain_comp
    import cordic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cordic_gain_comp_if.slave  bus
);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          mode_q, mode_d;
    logic [NUM_CH-1:0]             sgn_q, sgn_d;
    logic [NUM_CH-1:0][MAG_W-1:0]  mag_q, mag_d;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]             out_x_q, out_x_d;
    logic [DATA_W-1:0]             out_y_q, out_y_d;
    logic                          out_ovf_q, out_ovf_d;
    logic                          in_ready_c;

    logic [NUM_CH-1:0]             chan_comp;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc_step;
    logic [NUM_CH-1:0][MAG_W-1:0]  pack_mag;
    q78_sm_t [NUM_CH-1:0]          pack_sm;
    logic [NUM_CH-1:0]             pack_sat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Channel 1 is always compensated; channel 2 only in rotation mode.
            localparam bit ALWAYS_COMP = (gi == 0);
            logic [ACC_W-1:0] term;

            assign chan_comp[gi] = ALWAYS_COMP | mode_q;
            assign term          = k_term(mag_q[gi], idx_q);
            assign acc_step[gi]  = K_NEG[idx_q] ? (acc_q[gi] - term) : (acc_q[gi] + term);
            assign pack_mag[gi]  = chan_comp[gi]
                                 ? MAG_W'((acc_q[gi] + ROUND_HALF) >> GUARD_W)
                                 : mag_q[gi];

            cordic_sm_pack u_pack (
                .sign (sgn_q[gi]),
                .mag  (pack_mag[gi]),
                .sm   (pack_sm[gi]),
                .sat  (pack_sat[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        sgn_d     = sgn_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_ovf_d = out_ovf_q;
        in_ready_c = ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready)) && reset;

        unique case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && bus.out_ready) begin
                    state_d = IDLE;
                end
                // A drain and a new accept on the same edge go straight to MUL.
                if (bus.in_valid && in_ready_c) begin
                    mode_d   = bus.mode;
                    sgn_d    = {bus.res2_in[DATA_W-1], bus.res1_in[DATA_W-1]};
                    mag_d[0] = abs_mag(bus.res1_in);
                    mag_d[1] = abs_mag(bus.res2_in);
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (chan_comp[ch]) begin
                        acc_d[ch] = acc_step[ch];
                    end
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_TERMS - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                out_x_d   = pack_sm[0];
                out_y_d   = pack_sm[1];
                // Only the vectoring pass-through channel can saturate.
                out_ovf_d = |(pack_sat & {~mode_q, 1'b0});
                state_d   = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mode_q    <= 1'b0;
            sgn_q     <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            sgn_q     <= sgn_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Randomised and directed bench for cordic_gain_comp against an arithmetic model of K.
module tb_cordic_gain_comp;
    import cordic_pkg::*;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_txn = 0;
    int   last_acc_cyc = 0;
    int   last_drain_cyc = 0;
    bit   ov_prev = 0;
    exp_t exp_q[$];

    cordic_gain_comp_if bus();

    cordic_gain_comp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // K = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 = 4975/8192 exactly.
    function automatic logic [15:0] comp_ch(input logic [15:0] v);
        int s, m, r;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        r = (m * (4096 + 1024 - 128 - 16 - 1) + 4096) / 8192;
        return {(s < 0) && (r != 0), r[14:0]};
    endfunction

    function automatic logic [15:0] pass_ch(input logic [15:0] v, output logic ovf);
        int s, m;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        ovf = 1'b0;
        if (s == -32768) begin
            ovf = 1'b1;
            return 16'hFFFF;
        end
        return {s < 0, m[14:0]};
    endfunction

    // Output monitor: checks held results every cycle, latency on out_valid rise.
    always @(negedge clk) begin
        if (!reset) begin
            ov_prev = 0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    if (!ov_prev) check_eq("latency", cyc - exp_q[0].acc_cyc, 6);
                    check_eq("out_x", bus.out_x, exp_q[0].x);
                    check_eq("out_y", bus.out_y, exp_q[0].y);
                    check_eq("out_ovf", bus.out_ovf, exp_q[0].ovf);
                    if (!bus.out_ready) check_eq("in_ready_stalled", bus.in_ready, 0);
                    if (bus.out_ready) begin
                        n_txn++;
                        $display("txn %0d: x=%04h y=%04h ovf=%0b latency_ref=%0d",
                                 n_txn, bus.out_x, bus.out_y, bus.out_ovf, exp_q[0].acc_cyc);
                        void'(exp_q.pop_front());
                        last_drain_cyc = cyc + 1;
                    end
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(input logic m, input logic [15:0] r1, input logic [15:0] r2,
                        input logic [15:0] ex, input logic [15:0] ey, input logic eo,
                        input bit chk_ii);
        bit   got;
        exp_t e;
        bus.mode     = m;
        bus.res1_in  = r1;
        bus.res2_in  = r2;
        bus.in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
        end
        check_eq("accepted", 32'(got), 32'd1);
        if (got) begin
            e.x = ex; e.y = ey; e.ovf = eo; e.acc_cyc = cyc + 1;
            exp_q.push_back(e);
            if (chk_ii) check_eq("initiation_interval", e.acc_cyc - last_acc_cyc, 7);
            last_acc_cyc = e.acc_cyc;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic m, input logic [15:0] r1, input logic [15:0] r2,
                              input bit chk_ii);
        logic [15:0] ex, ey;
        logic        eo;
        ex = comp_ch(r1);
        eo = 1'b0;
        if (m) ey = comp_ch(r2);
        else   ey = pass_ch(r2, eo);
        send(m, r1, r2, ex, ey, eo, chk_ii);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] edges [4];
        edges[0] = 16'h8000; edges[1] = 16'h7FFF; edges[2] = 16'h0000; edges[3] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.res1_in   = '0;
        bus.res2_in   = '0;
        bus.out_ready = 1'b1;

        // Reset state, with a request already pending upstream.
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        #1;
        check_eq("rst_out_x", bus.out_x, 0);
        check_eq("rst_out_y", bus.out_y, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_ovf", bus.out_ovf, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        rel_cyc = cyc;
        #1;
        check_eq("in_ready_after_release", bus.in_ready, 1);

        // Directed test-plan vectors, with hand-derived expectations.
        send(1'b1, 16'h0100, 16'hFF00, 16'h009B, 16'h809B, 1'b0, 0);
        check_eq("first_accept_edge", last_acc_cyc, rel_cyc + 1);
        wait_empty();
        send(1'b0, 16'h1A60, 16'h0200, 16'h1004, 16'h0200, 1'b0, 0);
        wait_empty();
        send(1'b0, 16'h1A60, 16'h8000, 16'h1004, 16'hFFFF, 1'b1, 0);
        wait_empty();
        send(1'b1, 16'h8000, 16'hFFFF, 16'hCDBC, 16'h8001, 1'b0, 0);
        wait_empty();
        send(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0);
        wait_empty();

        // Backpressure: hold results 10 cycles while the next sample waits.
        bus.out_ready = 1'b0;
        send_model(1'b1, 16'h2345, 16'hC000, 0);
        bus.mode = 1'b0; bus.res1_in = 16'hF123; bus.res2_in = 16'h8000; bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
        check_eq("bp_out_valid", bus.out_valid, 1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_model(1'b0, 16'hF123, 16'h8000, 0);
        check_eq("bp_accept_on_drain", last_acc_cyc, last_drain_cyc);
        wait_empty();

        // Reset in the third MUL cycle discards the sample.
        send_model(1'b1, 16'h4000, 16'h9000, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_eq("midrst_out_x", bus.out_x, 0);
        check_eq("midrst_out_y", bus.out_y, 0);
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_out_ovf", bus.out_ovf, 0);
        check_eq("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        check_eq("midrst_in_ready_held", bus.in_ready, 0);
        reset = 1'b1;
        send(1'b1, 16'h0100, 16'hFF00, 16'h009B, 16'h809B, 1'b0, 0);
        wait_empty();

        // Back-to-back stream of 8 random samples.
        for (int i = 0; i < 8; i++) begin
            send_model(1'(($urandom) & 1), pick_operand(), pick_operand(), i != 0);
        end
        wait_empty();

        // Longer random stream mixing modes and edge operands.
        for (int i = 0; i < 24; i++) begin
            send_model(1'(($urandom) & 1), pick_operand(), pick_operand(), i != 0);
        end
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_gain_comp.md
# cordic_gain_comp

Post-processing stage directly downstream of `cordic`. It captures the raw two's-complement `res1`/`res2` pair, removes the CORDIC gain with a 5-term shift-add multiply by K ≈ 0.6072998, and rounds the result. It returns the values in the sign-magnitude Q7.8 format used for operands at the `cordic` inputs. A valid/ready handshake on each side lets the stage be stalled by its consumer.

## Interface
- `DATA_W`, 16, operand width (sign + 7 integer + 8 fraction bits)
- `GUARD_W`, 13, extra fraction bits in the accumulator; equals the largest K shift
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `mode`  in  1  sampled at accept; 1 = rotation (compensate both channels), 0 = vectoring (compensate `res1_in`, pass `res2_in`)
- `in_valid`  in  1  `res1_in`/`res2_in` hold a settled `cordic` result
- `in_ready`  out  1  stage can accept
- `res1_in`  in  DATA_W  `cordic` res1, two's complement Q7.8
- `res2_in`  in  DATA_W  `cordic` res2, two's complement Q7.8
- `out_valid`  out  1  results available
- `out_ready`  in  1  consumer takes results
- `out_x`  out  DATA_W  channel 1 result, sign-magnitude Q7.8
- `out_y`  out  DATA_W  channel 2 result, sign-magnitude Q7.8
- `out_ovf`  out  1  channel 2 pass-through saturated

## Operation
- **FSM states:** IDLE, MUL, ROUND, DONE. Term counter `idx` runs 0..4.
- **Accept:** a transfer occurs when `in_valid & in_ready`.
  - Per channel, latch the sign and the 17-bit magnitude |x|, so -32768 gives 32768.
  - Latch `mode`.
  - Clear the accumulators and set `idx` = 0. Next state is MUL.
- **MUL:** each cycle, every compensated channel adds `term[idx]` into a 30-bit accumulator: acc += sgn·(mag << GUARD_W) >> shift.
  - Term table: +2^-1, +2^-3, -2^-6, -2^-9, -2^-13.
  - The accumulator is exact; no bits are lost.
  - Leave MUL after `idx` = 4.
- **ROUND:** mag_out = (acc + 2^(GUARD_W-1)) >> GUARD_W, i.e. round half up on the magnitude.
  - The result is at most 19900, so it never overflows.
  - Reattach the sign. A zero magnitude always gets sign 0, so -0 is never produced.
- **Pass-through (`mode`=0, channel 2):** convert to sign-magnitude.
  - -32768 saturates to 0xFFFF and sets `out_ovf`.
  - `out_ovf` is always 0 in mode 1.
- **DONE:** `out_valid` = 1. Outputs are registered and stay stable until `out_valid & out_ready`.
- **Ready:** `in_ready` = (IDLE | (DONE & `out_ready`)) & `reset`, combinational.
  - A simultaneous drain and accept in DONE goes straight to MUL with the new operands.
  - DONE with `out_ready` and no new input goes to IDLE.
- `in_valid` in any state other than IDLE/DONE is ignored; the upstream must hold it.
- **Reset:** assertable at any cycle, including mid-MUL.
  - State goes to IDLE and accumulators are cleared.
  - `out_x`, `out_y` = 0; `out_valid`, `out_ovf` = 0; `in_ready` = 0 while `reset` is low.
  - A partially processed sample is discarded, not emitted.

## Timing
- Accept at edge E0 gives MUL during E0..E4, ROUND at E5, and `out_valid` high after E6. Latency is 6 cycles.
- Best-case initiation interval is 7 cycles, using the DONE-to-MUL overlap.
- `out_x`/`out_y`/`out_ovf` change only on the edge that enters DONE.
- The first accept is possible on the first rising edge after `reset` deasserts.

## Structure
- **Package `cordic_pkg`:**
  - `DATA_W`, `FRAC_W` = 8, `GUARD_W`, `NUM_TERMS` = 5
  - K term shift/sign arrays
  - FSM state enum
  - a Q7.8 sign-magnitude typedef, shared with `cordic` input formatting
- **Sub-module `cordic_sm_pack`:** combinational sign/17-bit magnitude to sign-magnitude DATA_W with saturation flag. Instantiated twice, once per channel.

## Test plan
- **Rotation, positive and negative inputs:** `mode`=1, `res1_in`=0x0100, `res2_in`=0xFF00 → `out_x`=0x009B, `out_y`=0x809B, `out_ovf`=0, `out_valid` 6 cycles after accept.
- **Vectoring, normal and saturating pass-through:** `mode`=0, `res1_in`=0x1A60, `res2_in`=0x0200 → `out_x`=0x1004, `out_y`=0x0200. Then `res2_in`=0x8000 → `out_y`=0xFFFF, `out_ovf`=1.
- **Edge values:** `mode`=1, `res1_in`=0x8000, `res2_in`=0xFFFF → `out_x`=0xCDBC (19900), `out_y`=0x8001. `res1_in`=0x0000 → `out_x`=0x0000.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`. Outputs stay stable, `in_ready`=0, and a held `in_valid` is accepted on the drain edge; the next `out_valid` follows 6 cycles later.
- **Reset mid-operation:** assert `reset` low in the 3rd MUL cycle. All outputs go to 0 immediately and `in_ready`=0. After release, a new sample completes with the correct value and no stale output appears.
- **Back-to-back stream:** 8 samples with `out_ready`=1 constantly. Each is accepted every 7 cycles and all results match a reference model bit-exactly.
